wbsp_watchdog: RTL and testbench

Pipelined-Wishbone bus watchdog inserted directly downstream of the AXI-lite to Wishbone bridge, between its Wishbone master port and the slave interconnect. It passes requests through combinationally, tracks outstanding requests, and bounds stall and acknowledgement latency. A slave that never stalls-off or never acks is cut off, and the master receives a bus error. This keeps the AXI side from deadlocking on a dead slave, because the bridge converts the error into a SLVERR/DECERR response.

---
 rtl/wbsp_watchdog.sv | 107 ++++++++++
 tb/tb_wbsp_watchdog.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wbsp_watchdog.sv
// Pipelined Wishbone watchdog between a bridge master port and the slave interconnect.
// Requests and responses pass combinationally; a slave that stalls or withholds acks too long is cut off with a bus error.
//
// state  | meaning
// ACTIVE | requests and responses pass through, outstanding and progress timer tracked
// FAULT  | slave isolated, master stalled, waiting for the master to drop cyc
module wbsp_watchdog #(
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int LGDEPTH = 5,
   parameter int TIMEOUT = 1023
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [AW-1:0]   i_wb_addr,
   input  logic [DW-1:0]   i_wb_data,
   input  logic [DW/8-1:0] i_wb_sel,
   output logic            o_wb_stall,
   output logic            o_wb_ack,
   output logic            o_wb_err,
   output logic [DW-1:0]   o_wb_data,
   output logic            o_slv_cyc,
   output logic            o_slv_stb,
   output logic            o_slv_we,
   output logic [AW-1:0]   o_slv_addr,
   output logic [DW-1:0]   o_slv_data,
   output logic [DW/8-1:0] o_slv_sel,
   input  logic            i_slv_stall,
   input  logic            i_slv_ack,
   input  logic            i_slv_err,
   input  logic [DW-1:0]   i_slv_data,
   output logic            o_timeout
);

   typedef enum logic {ACTIVE = 1'b0, FAULT = 1'b1} state_t;

   localparam logic [LGDEPTH-1:0] MAX_OUT = '1;
   localparam logic [15:0]        TC      = 16'(TIMEOUT - 1);

   state_t             state;
   logic [LGDEPTH-1:0] outstanding;
   logic [15:0]        timer;
   logic               fault_err;
   logic               timeout_q;

   logic active, full, pending, req_stall, accept, resp, fire, timer_clr;

   // Gating with i_reset keeps every request/response output low while reset is held.
   assign active    = (state == ACTIVE) && !i_reset;
   assign full      = (outstanding == MAX_OUT);
   assign pending   = (outstanding != '0);
   assign req_stall = i_slv_stall | full;
   assign accept    = active & i_wb_cyc & i_wb_stb & ~req_stall;
   assign resp      = active & i_wb_cyc & (i_slv_ack | i_slv_err) & pending;
   assign fire      = active & (timer == TC) & ~accept & ~resp;
   assign timer_clr = fire | (state == FAULT) | accept | resp | ~i_wb_cyc
                    | (~i_wb_stb & ~pending);

   assign o_slv_cyc  = active & i_wb_cyc;
   assign o_slv_stb  = active & i_wb_cyc & i_wb_stb & ~full;
   assign o_slv_we   = ~i_reset & i_wb_we;
   assign o_slv_addr = i_reset ? '0 : i_wb_addr;
   assign o_slv_data = i_reset ? '0 : i_wb_data;
   assign o_slv_sel  = i_reset ? '0 : i_wb_sel;

   assign o_wb_stall = ~i_reset & ((state == FAULT) | req_stall);
   assign o_wb_ack   = active & i_wb_cyc & i_slv_ack & ~i_slv_err & pending;
   assign o_wb_err   = (active & i_wb_cyc & i_slv_err) | fault_err;
   assign o_wb_data  = i_slv_data;
   assign o_timeout  = timeout_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= ACTIVE;
         outstanding <= '0;
         timer       <= '0;
         fault_err   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         fault_err <= fire;
         timeout_q <= fire;

         case (state)
            ACTIVE:  if (fire)      state <= FAULT;
            FAULT:   if (!i_wb_cyc) state <= ACTIVE;
            default:                state <= ACTIVE;
         endcase

         // A slave error aborts the whole burst, so the count restarts from zero.
         if (fire || !i_wb_cyc || state == FAULT || i_slv_err)
            outstanding <= '0;
         else if (accept && !resp)
            outstanding <= outstanding + 1'b1;
         else if (resp && !accept)
            outstanding <= outstanding - 1'b1;

         if (timer_clr)
            timer <= '0;
         else if (timer != 16'hffff)
            timer <= timer + 1'b1;
      end
   end

endmodule

// File: tb/tb_wbsp_watchdog.sv
// Randomized bench for wbsp_watchdog against a rule-level reference model.
// Small depth and timeout make full-counter and timeout corners frequent.
module tb_wbsp_watchdog;
   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int LGD = 2;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc, stb, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [SW-1:0] sel;
   logic          stall, ack, err;
   logic [DW-1:0] rdata;
   logic          slv_stall, slv_ack, slv_err;
   logic [DW-1:0] slv_rdata;
   logic          slv_cyc, slv_stb, slv_we;
   logic [AW-1:0] slv_addr;
   logic [DW-1:0] slv_wdata;
   logic [SW-1:0] slv_sel;
   logic          timeout;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: outstanding count, cycles since progress, fault flag, pending fault pulse.
   int m_out, m_idle, m_fires, dut_tmo;
   bit m_fault, m_ferr;

   always #5 clk = ~clk;

   wbsp_watchdog #(.AW(AW), .DW(DW), .LGDEPTH(LGD), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
      .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata),
      .o_slv_cyc(slv_cyc), .o_slv_stb(slv_stb), .o_slv_we(slv_we),
      .o_slv_addr(slv_addr), .o_slv_data(slv_wdata), .o_slv_sel(slv_sel),
      .i_slv_stall(slv_stall), .i_slv_ack(slv_ack), .i_slv_err(slv_err),
      .i_slv_data(slv_rdata), .o_timeout(timeout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pass_vec();
      return {1'b0, slv_we, slv_addr, slv_wdata, slv_sel};
   endfunction

   task automatic model_reset();
      m_out = 0; m_idle = 0; m_fault = 0; m_ferr = 0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_stall", stall, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_tmo", timeout, 0);
      chk("rst_scyc", slv_cyc, 0);
      chk("rst_sstb", slv_stb, 0);
      chk("rst_pass", pass_vec(), 0);
      chk("rst_rdata", rdata, slv_rdata);
   endtask

   // Called just after a rising edge with inputs already applied; returns just after the next one.
   task automatic run_cycle();
      bit act, full, st_e, acc, rsp, fire;
      #1;
      act  = !m_fault;
      full = (m_out == (1 << LGD) - 1);
      st_e = m_fault || slv_stall || full;
      acc  = act && cyc && stb && !st_e;
      rsp  = act && cyc && (slv_ack || slv_err) && m_out > 0;
      fire = act && (m_idle == TMO - 1) && !acc && !rsp;
      @(negedge clk);
      chk("stall", stall, st_e);
      chk("ack", ack, act && cyc && slv_ack && !slv_err && m_out > 0);
      chk("err", err, (act && cyc && slv_err) || m_ferr);
      chk("tmo", timeout, m_ferr);
      chk("scyc", slv_cyc, act && cyc);
      chk("sstb", slv_stb, act && cyc && stb && !full);
      chk("pass", pass_vec(), {1'b0, we, addr, wdata, sel});
      chk("rdata", rdata, slv_rdata);
      if (timeout) dut_tmo++;
      if (fire) m_fires++;

      if (fire || m_fault || acc || rsp || !cyc || (!stb && m_out == 0)) m_idle = 0;
      else if (m_idle < 65535) m_idle++;

      if (fire || !cyc || m_fault || (act && slv_err)) m_out = 0;
      else m_out = m_out + int'(acc) - int'(rsp);

      if (m_fault) m_fault = cyc;
      else m_fault = fire;
      m_ferr = fire;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit c, input bit s, input bit st, input bit a, input bit e);
      cyc = c; stb = s; slv_stall = st; slv_ack = a; slv_err = e;
      we = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
      sel = SW'($urandom); slv_rdata = $urandom;
      run_cycle();
   endtask

   initial begin
      bit c, s, st, a, e;
      int mode, len;
      rst = 1'b1;
      cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
      slv_stall = 0; slv_ack = 0; slv_err = 0; slv_rdata = 32'h1234_5678;
      m_fires = 0; dut_tmo = 0;
      model_reset();
      #2;
      chk_reset_outputs();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // single read returning 0xDEADBEEF after three cycles
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      cyc = 1; stb = 0; slv_stall = 0; slv_ack = 1; slv_err = 0; slv_rdata = 32'hDEAD_BEEF;
      run_cycle();
      drive(0, 0, 0, 0, 0);

      // dead slave: one accepted request, never acked
      drive(1, 1, 0, 0, 0);
      for (int i = 0; i < TMO + 3; i++) drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);

      // stall held high with a request waiting
      for (int i = 0; i < TMO + 3; i++) drive(1, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0);

      // full counter: fourth request stalled until acks drain
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0);
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);

      // master abort with two outstanding, late ack
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);

      // slave error on the second of two requests
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 1);
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);

      // asynchronous reset with one request in flight
      drive(1, 1, 0, 0, 0);
      cyc = 1; stb = 1; slv_ack = 0; slv_err = 0; slv_stall = 0; slv_rdata = $urandom;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      model_reset();
      cyc = 0; stb = 0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      for (int seg = 0; seg < 60; seg++) begin
         mode = $urandom_range(0, 3);
         len  = $urandom_range(4, 30);
         for (int i = 0; i < len; i++) begin
            c  = m_fault ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) != 0);
            s  = ($urandom_range(0, 2) != 0);
            st = (mode == 3) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
            a  = (mode < 2) ? ($urandom_range(0, 9) < 4) : 1'b0;
            e  = (mode < 2) ? ($urandom_range(0, 39) == 0) : 1'b0;
            drive(c, s, st, a, e);
         end
      end

      chk("tmo_pulses", 64'(dut_tmo), 64'(m_fires));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
